// File: rtl/core_mem_sequencer_if.sv
// Shared single-ported memory bus between the sequencer (master) and the unified memory (slave).
// A transfer completes on any cycle where mem_req and mem_ack are both high.
interface core_mem_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/core_mem_sequencer.sv
// Multi-cycle sequencer sharing one unified memory between instruction fetch and data access;
// the commit strobe is the only enable the datapath may use for PC and register-file updates.
module core_mem_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 pc_next,
  input  logic [31:0]                 core_addr,
  input  logic [31:0]                 core_wdata,
  input  logic                        core_mem_write,
  input  logic                        core_mem_read,
  input  logic                        core_halt,
  output logic [31:0]                 pc,
  output logic [31:0]                 instruction,
  output logic [31:0]                 load_data,
  output logic                        commit,
  output logic                        halted,
  output logic                        bus_error,
  output logic [31:0]                 retired,
  core_mem_sequencer_if.master        mem
);

  // Counter only needs to reach TIMEOUT-1: the TIMEOUT-th unacked cycle triggers the error.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StBoot,
    StFetch,
    StExec,
    StData,
    StCommit,
    StHalted
  } state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [31:0]     instruction_q;
  logic [31:0]     load_data_q;
  logic [31:0]     retired_q;
  logic            commit_q;
  logic            halted_q;
  logic            bus_error_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic [CntW-1:0] wait_cnt_q;
  logic            wait_expired;

  assign wait_expired = (wait_cnt_q == WaitLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      instruction_q <= 32'h0;
      load_data_q   <= 32'h0;
      retired_q     <= 32'h0;
      commit_q      <= 1'b0;
      halted_q      <= 1'b0;
      bus_error_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      wait_cnt_q    <= '0;
    end else begin
      commit_q <= 1'b0;
      case (state_q)
        StBoot: begin
          // Fetch request is raised on entry so a zero-wait fetch completes in one cycle.
          mem_req_q  <= (pc_q[1:0] == 2'b00);
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q;
          wait_cnt_q <= '0;
          state_q    <= StFetch;
        end
        StFetch: begin
          if (pc_q[1:0] != 2'b00) begin
            bus_error_q <= 1'b1;
            halted_q    <= 1'b1;
            state_q     <= StHalted;
          end else if (mem.mem_ack) begin
            instruction_q <= mem.mem_rdata;
            mem_req_q     <= 1'b0;
            state_q       <= StExec;
          end else if (wait_expired) begin
            bus_error_q <= 1'b1;
            halted_q    <= 1'b1;
            mem_req_q   <= 1'b0;
            state_q     <= StHalted;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StExec: begin
          if (core_mem_write || core_mem_read) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= core_mem_write;
            mem_addr_q  <= core_addr;
            mem_wdata_q <= core_wdata;
            wait_cnt_q  <= '0;
            state_q     <= StData;
          end else begin
            commit_q <= 1'b1;
            state_q  <= StCommit;
          end
        end
        StData: begin
          if (mem.mem_ack) begin
            // A combined read+write is treated as a store: load_data is left untouched.
            if (!mem_we_q) begin
              load_data_q <= mem.mem_rdata;
            end
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            commit_q  <= 1'b1;
            state_q   <= StCommit;
          end else if (wait_expired) begin
            bus_error_q <= 1'b1;
            halted_q    <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            state_q     <= StHalted;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StCommit: begin
          retired_q <= retired_q + 32'd1;
          if (core_halt) begin
            halted_q <= 1'b1;
            state_q  <= StHalted;
          end else begin
            pc_q       <= pc_next;
            mem_req_q  <= (pc_next[1:0] == 2'b00);
            mem_we_q   <= 1'b0;
            mem_addr_q <= pc_next;
            wait_cnt_q <= '0;
            state_q    <= StFetch;
          end
        end
        StHalted: begin
          state_q <= StHalted;
        end
        default: begin
          halted_q  <= 1'b1;
          mem_req_q <= 1'b0;
          state_q   <= StHalted;
        end
      endcase
    end
  end

  assign pc            = pc_q;
  assign instruction   = instruction_q;
  assign load_data     = load_data_q;
  assign retired       = retired_q;
  assign commit        = commit_q;
  assign halted        = halted_q;
  assign bus_error     = bus_error_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_core_mem_sequencer.sv
// Scoreboard bench for core_mem_sequencer: an instruction-level model predicts bus transfers and
// commits; a memory responder with randomized wait states and a monitor check the DUT against it.
module tb_core_mem_sequencer;
  localparam int unsigned TIMEOUT   = 16;
  localparam logic [31:0] DATA_BASE = 32'h0000_1000;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] ret;
    logic [31:0] ld;
    int unsigned cyc;
  } cmt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_next, core_addr, core_wdata;
  logic        core_mem_write, core_mem_read, core_halt;
  logic [31:0] pc, instruction, load_data, retired;
  logic        commit, halted, bus_error;

  core_mem_sequencer_if bus ();

  core_mem_sequencer #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_next        (pc_next),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_mem_write (core_mem_write),
    .core_mem_read  (core_mem_read),
    .core_halt      (core_halt),
    .pc             (pc),
    .instruction    (instruction),
    .load_data      (load_data),
    .commit         (commit),
    .halted         (halted),
    .bus_error      (bus_error),
    .retired        (retired),
    .mem            (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Datapath stand-in: op = inst[1:0] (0 alu, 1 load, 2 store, 3 store+read), inst[3] branch.
  logic        force_next_en;
  logic [31:0] force_next;
  logic        halt_en;
  logic [31:0] halt_at;

  always_comb begin
    core_mem_read  = (instruction[1:0] == 2'd1) || (instruction[1:0] == 2'd3);
    core_mem_write = instruction[1];
    core_addr      = DATA_BASE + {24'h0, instruction[9:4], 2'b00};
    core_wdata     = instruction ^ 32'h5A5A_5A5A;
    core_halt      = halt_en && (retired == halt_at);
    if (force_next_en)       pc_next = force_next;
    else if (instruction[3]) pc_next = {24'h0, instruction[23:18], 2'b00};
    else                     pc_next = (pc + 32'd4) & 32'h0000_00FC;
  end

  // Words 0..63: program at 0x000..0x0FC; words 64..127: data at 0x1000..0x10FC.
  logic [31:0] rmem [128];
  logic [31:0] mmem [128];

  function automatic int widx(input logic [31:0] a);
    return (a >= DATA_BASE) ? 64 + int'(a[7:2]) : int'(a[7:2]);
  endfunction

  task automatic init_mem(input bit rand_prog);
    for (int i = 0; i < 128; i++) begin
      if (i < 64) mmem[i] = rand_prog ? ($urandom() & 32'hFFFF_FFFB) : 32'h0;
      else        mmem[i] = $urandom();
      rmem[i] = mmem[i];
    end
  endtask

  bus_t        exp_bus[$];
  cmt_t        exp_cmt[$];
  int unsigned resp_wait[$];

  // Instruction-level reference: walks the program and predicts every transfer and commit.
  task automatic run_model(input int unsigned stop, input int unsigned maxwait,
                           output logic [31:0] fpc);
    logic [31:0] mpc, inst, ld;
    int unsigned t, wf, wd, ccyc;
    bus_t b;
    cmt_t c;
    mpc = 32'h0;
    ld  = 32'h0;
    t   = 1;
    for (int k = 0; k < int'(stop); k++) begin
      inst = mmem[widx(mpc)];
      wf = $urandom_range(maxwait, 0);
      resp_wait.push_back(wf);
      b.addr = mpc; b.we = 1'b0; b.wdata = 32'h0;
      exp_bus.push_back(b);
      ccyc = t + 2 + wf;
      if (inst[1:0] != 2'd0) begin
        wd = $urandom_range(maxwait, 0);
        resp_wait.push_back(wd);
        b.addr  = DATA_BASE + 32'(inst[9:4]) * 4;
        b.we    = inst[1];
        b.wdata = inst ^ 32'h5A5A_5A5A;
        exp_bus.push_back(b);
        ccyc += 1 + wd;
        if (b.we) mmem[widx(b.addr)] = b.wdata;
        else      ld = mmem[widx(b.addr)];
      end
      c.pc = mpc; c.inst = inst; c.ret = 32'(k); c.ld = ld; c.cyc = ccyc;
      exp_cmt.push_back(c);
      if (k != int'(stop) - 1) begin
        if (inst[3]) mpc = 32'(inst[23:18]) * 4;
        else         mpc = (mpc + 4) % 256;
      end
      t = ccyc + 1;
    end
    fpc = mpc;
  endtask

  int unsigned cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Memory responder: mode 0 uses queued waits, 1 never acks, 2 acks only program fetches.
  int unsigned resp_mode;
  int unsigned resp_remain;
  bit          resp_busy;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    resp_busy     = 1'b0;
    resp_remain   = 0;
    forever begin
      @(negedge clk);
      if (reset || !bus.mem_req) begin
        bus.mem_ack = 1'b0;
        resp_busy   = 1'b0;
      end else begin
        if (!resp_busy) begin
          resp_busy   = 1'b1;
          resp_remain = (resp_wait.size() > 0) ? resp_wait.pop_front() : 0;
        end
        if (resp_mode == 1 || (resp_mode == 2 && bus.mem_addr >= DATA_BASE)) begin
          bus.mem_ack = 1'b0;
        end else if (resp_remain == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rmem[widx(bus.mem_addr)];
          if (bus.mem_we) rmem[widx(bus.mem_addr)] = bus.mem_wdata;
          resp_busy = 1'b0;
        end else begin
          resp_remain--;
          bus.mem_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT completes a transfer or commits.
  bit          sb_en;
  bit          prev_wait;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  bus_t        mb;
  cmt_t        mc;

  initial begin
    prev_wait = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!sb_en || reset) begin
        prev_wait = 1'b0;
      end else begin
        if (prev_wait && bus.mem_req) begin
          check("req_hold_addr", bus.mem_addr, prev_addr);
          check("req_hold_we", 32'(bus.mem_we), 32'(prev_we));
          check("req_hold_wdata", bus.mem_wdata, prev_wdata);
        end
        if (bus.mem_req && bus.mem_ack) begin
          if (exp_bus.size() == 0) begin
            n_chk++;
            $display("FAIL bus_unexpected: got transfer at %h, required none", bus.mem_addr);
          end else begin
            mb = exp_bus.pop_front();
            check("bus_addr", bus.mem_addr, mb.addr);
            check("bus_we", 32'(bus.mem_we), 32'(mb.we));
            if (mb.we) check("bus_wdata", bus.mem_wdata, mb.wdata);
          end
        end
        prev_wait  = bus.mem_req && !bus.mem_ack;
        prev_addr  = bus.mem_addr;
        prev_we    = bus.mem_we;
        prev_wdata = bus.mem_wdata;
        if (commit) begin
          if (exp_cmt.size() == 0) begin
            n_chk++;
            $display("FAIL commit_unexpected: got commit at pc %h, required none", pc);
          end else begin
            mc = exp_cmt.pop_front();
            check("commit_pc", pc, mc.pc);
            check("commit_inst", instruction, mc.inst);
            check("commit_retired", retired, mc.ret);
            check("commit_load_data", load_data, mc.ld);
            check("commit_cycle", 32'(cyc), 32'(mc.cyc));
          end
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    sb_en = 1'b0;
    exp_bus.delete();
    exp_cmt.delete();
    resp_wait.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int unsigned budget);
    int unsigned n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic program_run(input bit rand_prog, input int unsigned stop,
                             input int unsigned maxwait);
    logic [31:0] fpc;
    do_reset();
    init_mem(rand_prog);
    run_model(stop, maxwait, fpc);
    resp_mode     = 0;
    force_next_en = 1'b0;
    halt_en       = 1'b1;
    halt_at       = 32'(stop - 1);
    sb_en         = 1'b1;
    release_reset();
    wait_halt(stop * 12 + 20);
    @(negedge clk);
    #1;
    check("run_pc_final", pc, fpc);
    check("run_retired", retired, 32'(stop));
    check("run_bus_error", 32'(bus_error), 32'd0);
    check("run_bus_left", 32'(exp_bus.size()), 32'd0);
    check("run_cmt_left", 32'(exp_cmt.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("halted_no_req", 32'(bus.mem_req), 32'd0);
      check("halted_no_commit", 32'(commit), 32'd0);
    end
  endtask

  int unsigned n_req, n_cmt, n;

  initial begin
    reset         = 1'b1;
    sb_en         = 1'b0;
    force_next_en = 1'b0;
    force_next    = 32'h0;
    halt_en       = 1'b0;
    halt_at       = 32'h0;
    resp_mode     = 0;
    init_mem(1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_flags", {29'h0, commit, halted, bus_error}, 32'h0);
    check("rst_mem_req", {30'h0, bus.mem_req, bus.mem_we}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);

    // Straight-line ALU code at 0,4,8 with zero-wait memory, halting on the third.
    program_run(1'b0, 3, 0);
    // Random programs with loads, stores, branches and wait states.
    program_run(1'b1, 40, 3);
    program_run(1'b1, 30, 2);

    // Memory never acknowledges: fetch must time out after TIMEOUT request cycles.
    do_reset();
    init_mem(1'b0);
    resp_mode = 1;
    halt_en   = 1'b0;
    release_reset();
    n_req = 0; n_cmt = 0; n = 0;
    while (!halted && n < 60) begin
      @(negedge clk);
      #1;
      if (halted) break;
      if (bus.mem_req) n_req++;
      if (commit) n_cmt++;
      n++;
    end
    check("to_req_cycles", 32'(n_req), 32'(TIMEOUT));
    check("to_halted", 32'(halted), 32'd1);
    check("to_bus_error", 32'(bus_error), 32'd1);
    check("to_commits", 32'(n_cmt), 32'd0);
    check("to_req_dropped", 32'(bus.mem_req), 32'd0);

    // Misaligned next PC: one commit, then a fetch that raises bus_error without a request.
    do_reset();
    init_mem(1'b0);
    resp_mode     = 0;
    force_next_en = 1'b1;
    force_next    = 32'h0000_0006;
    release_reset();
    n_req = 0; n_cmt = 0; n = 0;
    while (!halted && n < 40) begin
      @(negedge clk);
      #1;
      if (bus.mem_req) n_req++;
      if (commit) n_cmt++;
      n++;
    end
    check("mis_halted", 32'(halted), 32'd1);
    check("mis_bus_error", 32'(bus_error), 32'd1);
    check("mis_req_count", 32'(n_req), 32'd1);
    check("mis_commits", 32'(n_cmt), 32'd1);
    check("mis_pc", pc, 32'h0000_0006);
    check("mis_retired", retired, 32'd1);
    force_next_en = 1'b0;

    // Reset while a load waits for its ack.
    do_reset();
    init_mem(1'b0);
    mmem[0] = 32'h0000_0011;
    rmem[0] = 32'h0000_0011;
    resp_mode = 2;
    release_reset();
    n = 0;
    while (!(bus.mem_req && bus.mem_addr >= DATA_BASE) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (2) @(negedge clk);
    #1;
    check("data_wait_req", 32'(bus.mem_req), 32'd1);
    check("data_wait_addr", bus.mem_addr, 32'h0000_1004);
    check("data_wait_we", 32'(bus.mem_we), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("abort_req", 32'(bus.mem_req), 32'd0);
    check("abort_pc", pc, 32'h0);
    check("abort_retired", retired, 32'h0);
    check("abort_instruction", instruction, 32'h0);
    resp_mode = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("boot_no_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    #1;
    check("refetch_req", 32'(bus.mem_req), 32'd1);
    check("refetch_addr", bus.mem_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/core_mem_sequencer.md
Name: core_mem_sequencer

Overview:
- Multi-cycle sequencer that shares one single-ported unified memory between instruction fetch and data load/store for the single-cycle datapath.
- Fetches the instruction at the current PC and holds it stable for the datapath. Performs the data access the datapath requests, then pulses a commit strobe that gates the PC and register-file updates.
- Sits between the datapath and the memory, replacing direct ROM/RAM hookup; also detects halt, misaligned fetch and memory timeout.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles a memory request may wait for mem_ack before bus error (≥1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pc_next  input  32  next-PC from datapath (nPc), sampled at commit
- core_addr  input  32  data address from datapath (aluResult)
- core_wdata  input  32  store data from datapath (regData2)
- core_mem_write  input  1  current instruction is a store
- core_mem_read  input  1  current instruction is a load (memToReg)
- core_halt  input  1  current instruction is halt
- pc  output  32  current fetch PC
- instruction  output  32  latched instruction, stable from EXEC through COMMIT
- load_data  output  32  latched load data (memOut to datapath)
- commit  output  1  one-cycle strobe: datapath may write registers / update PC
- halted  output  1  sequencer stopped (halt or error)
- bus_error  output  1  sticky: timeout or misaligned fetch
- retired  output  32  count of committed instructions
- mem_req  output  1  memory request, held until acked
- mem_we  output  1  write enable, valid with mem_req
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, valid when mem_ack
- mem_ack  input  1  transfer completes on any cycle with mem_req && mem_ack

Behaviour:
- States: BOOT, FETCH, EXEC, DATA, COMMIT, HALTED. Reset→BOOT; BOOT→FETCH after one clock.
- Reset values: pc=RESET_PC; instruction=0; load_data=0; retired=0; commit=0; halted=0; bus_error=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; wait counter=0.
- Reset asserted mid-transaction: immediate abort, all of the above values. No memory handshake completes.
- FETCH:
  - If pc[1:0]≠0: set bus_error, go to HALTED, issue no request.
  - Otherwise mem_req=1, mem_we=0, mem_addr=pc. On ack, instruction←mem_rdata and go to EXEC.
- EXEC: exactly one cycle, mem_req=0, for datapath settling. Then:
  - core_mem_write or core_mem_read set → DATA.
  - Otherwise → COMMIT.
- DATA: mem_req=1, mem_addr=core_addr, mem_wdata=core_wdata, mem_we=core_mem_write.
  - Both write and read set: write wins; load_data unchanged.
  - On ack: if read-only, load_data←mem_rdata. Go to COMMIT.
- Address/data stability: mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and no ack. The values are latched on entry to DATA.
- COMMIT: commit=1 for exactly one cycle; retired += 1 (wraps 2^32−1→0).
  - core_halt=1 (sampled in COMMIT): pc unchanged, go to HALTED.
  - Otherwise pc←pc_next, go to FETCH.
- HALTED: halted=1, mem_req=0, commit=0. Leaves only via reset.
- Timeout: wait counter clears on entering FETCH/DATA and increments each unacked request cycle. When it reaches TIMEOUT without ack: bus_error=1, mem_req drops next cycle, go to HALTED, no commit. An ack in the TIMEOUT-th cycle itself counts as success.
- Latency:
  - Zero-wait memory (ack same cycle as req): non-memory instruction takes 3 cycles (FETCH, EXEC, COMMIT); load/store takes 4.
  - Each wait cycle adds 1.
- commit is the only enable the datapath may use for the PC and register-file write. No state updates occur outside COMMIT.

Test Plan:
- Reset, zero-wait memory, 3 ALU instructions at 0,4,8 → mem_req addresses 0,4,8; commit every 3rd cycle; retired=3; pc=12.
- Load at PC 0, core_addr=0x100, mem_rdata=0xDEADBEEF, ack delayed 2 cycles → mem_addr 0x100 held 3 cycles with mem_we=0; load_data=0xDEADBEEF; commit in 7th cycle after BOOT.
- Store with core_mem_write=1 and core_mem_read=1, core_wdata=0x55 → mem_we=1, mem_wdata=0x55, load_data unchanged, one commit.
- core_halt=1 on instruction at 0x8 → commit pulses once, pc stays 0x8, halted=1, mem_req=0 thereafter.
- mem_ack never asserted, TIMEOUT=16 → bus_error=1 and halted=1 after 16 request cycles; commit never asserted. Repeat with pc_next=0x6: next FETCH sets bus_error with no mem_req.
- Reset asserted during DATA wait → mem_req drops immediately, pc=RESET_PC, retired=0; FETCH restarts one cycle after release.
